uart_bridge: RTL and testbench

Buffered CPU-side front end for the existing uart core, sitting between the peripheral address decoder and the uart.
- TX FIFO: absorbs CPU byte writes and drains them to the uart through its wr/busy handshake.
- RX FIFO: drains received bytes from the uart through its valid/rd handshake and presents them to CPU reads.
- Lets software burst-write strings and tolerate read latency without polling busy per byte.

---
 rtl/uart_bridge_pkg.sv | 19 +
 rtl/sync_fifo.sv | 52 +++++
 rtl/uart_bridge.sv | 128 ++++++++++++
 tb/tb_uart_bridge.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_bridge_pkg.sv
// Shared definitions for the uart_bridge CPU front end: register map,
// status bit positions and FSM state types.
package uart_bridge_pkg;

    localparam logic REG_DATA   = 1'b0;
    localparam logic REG_STATUS = 1'b1;

    localparam int unsigned ST_TX_FULL      = 0;
    localparam int unsigned ST_RX_NOT_EMPTY = 1;
    localparam int unsigned ST_TX_EMPTY     = 2;
    localparam int unsigned ST_RX_FULL      = 3;
    localparam int unsigned ST_TX_OVERFLOW  = 4;
    localparam int unsigned ST_RX_COUNT_LSB = 8;
    localparam int unsigned ST_TX_COUNT_LSB = 16;

    typedef enum logic [1:0] {T_IDLE, T_LAUNCH, T_GUARD, T_WAIT} tx_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ACK, R_SETTLE} rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head and occupancy count.
// Full/empty are judged on pre-edge state; simultaneous push and pop are both honoured.
module sync_fifo #(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset_i,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_bridge.sv
// Buffered CPU front end for the uart core: TX FIFO drained through wr/busy,
// RX FIFO filled through valid/rd, edge-qualified CPU strobes.
module uart_bridge #(
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic        clk,
    input  logic        reset_i,
    input  logic        cpu_wr_i,
    input  logic        cpu_rd_i,
    input  logic        cpu_reg_i,
    input  logic [7:0]  cpu_data_i,
    output logic [31:0] cpu_data_o,
    output logic [7:0]  uart_tx_data_o,
    output logic        uart_wr_o,
    input  logic        uart_busy_i,
    input  logic [7:0]  uart_rx_data_i,
    input  logic        uart_valid_i,
    output logic        uart_rd_o,
    output logic        irq_o
);
    import uart_bridge_pkg::*;

    logic          wr_q, rd_q, wr_edge, rd_edge, status_rd;
    logic          tx_push, tx_pop, tx_full, tx_empty;
    logic          rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0]    tx_head, rx_head;
    logic [CW-1:0] tx_count, rx_count;
    logic          tx_overflow;
    logic [31:0]   status;
    tx_state_t     tx_state, tx_next;
    rx_state_t     rx_state, rx_next;

    // A held strobe counts once: act only on the low-to-high transition.
    assign wr_edge   = cpu_wr_i && !wr_q;
    assign rd_edge   = cpu_rd_i && !rd_q;
    assign tx_push   = wr_edge && (cpu_reg_i == REG_DATA);
    assign rx_pop    = rd_edge && (cpu_reg_i == REG_DATA);
    assign status_rd = rd_edge && (cpu_reg_i == REG_STATUS);

    sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_tx_fifo (
        .clk(clk), .reset_i(reset_i), .push(tx_push), .pop(tx_pop), .din(cpu_data_i),
        .dout(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_count)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_rx_fifo (
        .clk(clk), .reset_i(reset_i), .push(rx_push), .pop(rx_pop), .din(uart_rx_data_i),
        .dout(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count)
    );

    always_ff @(posedge clk) begin
        if (reset_i) begin
            wr_q           <= 1'b0;
            rd_q           <= 1'b0;
            tx_overflow    <= 1'b0;
            irq_o          <= 1'b0;
            uart_tx_data_o <= '0;
            tx_state       <= T_IDLE;
            rx_state       <= R_IDLE;
        end else begin
            wr_q     <= cpu_wr_i;
            rd_q     <= cpu_rd_i;
            irq_o    <= !rx_empty;
            tx_state <= tx_next;
            rx_state <= rx_next;
            if (tx_pop) uart_tx_data_o <= tx_head;
            // A fresh drop wins over a same-cycle status read clearing the flag.
            if (tx_push && tx_full) tx_overflow <= 1'b1;
            else if (status_rd)     tx_overflow <= 1'b0;
        end
    end

    always_comb begin
        tx_next   = tx_state;
        tx_pop    = 1'b0;
        uart_wr_o = 1'b0;
        unique case (tx_state)
            T_IDLE: begin
                if (!tx_empty && !uart_busy_i) begin
                    tx_pop  = 1'b1;
                    tx_next = T_LAUNCH;
                end
            end
            T_LAUNCH: begin
                uart_wr_o = 1'b1;
                tx_next   = T_GUARD;
            end
            T_GUARD: tx_next = T_WAIT;
            T_WAIT:  if (!uart_busy_i) tx_next = T_IDLE;
            default: tx_next = T_IDLE;
        endcase
    end

    always_comb begin
        rx_next   = rx_state;
        rx_push   = 1'b0;
        uart_rd_o = 1'b0;
        unique case (rx_state)
            R_IDLE: begin
                if (uart_valid_i && !rx_full) begin
                    rx_push = 1'b1;
                    rx_next = R_ACK;
                end
            end
            R_ACK: begin
                uart_rd_o = 1'b1;
                rx_next   = R_SETTLE;
            end
            R_SETTLE: rx_next = R_IDLE;
            default:  rx_next = R_IDLE;
        endcase
    end

    always_comb begin
        status                              = '0;
        status[ST_TX_FULL]                  = tx_full;
        status[ST_RX_NOT_EMPTY]             = !rx_empty;
        status[ST_TX_EMPTY]                 = tx_empty;
        status[ST_RX_FULL]                  = rx_full;
        status[ST_TX_OVERFLOW]              = tx_overflow;
        status[ST_RX_COUNT_LSB +: CW]       = rx_count;
        status[ST_TX_COUNT_LSB +: CW]       = tx_count;
        if (cpu_reg_i == REG_STATUS) cpu_data_o = status;
        else if (rx_empty)           cpu_data_o = '0;
        else                         cpu_data_o = {24'd0, rx_head};
    end

endmodule

// File: tb/tb_uart_bridge.sv
// Self-checking bench for uart_bridge: behavioural uart model plus queue-based
// reference of FIFO contents, overflow flag and status word.
module tb_uart_bridge;
    import uart_bridge_pkg::*;

    localparam int unsigned DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset_i, cpu_wr_i, cpu_rd_i, cpu_reg_i;
    logic [7:0]  cpu_data_i, uart_tx_data_o, uart_rx_data_i;
    logic [31:0] cpu_data_o;
    logic        uart_wr_o, uart_busy_i, uart_valid_i, uart_rd_o, irq_o;

    int          n_checks = 0;
    int          n_fail   = 0;

    byte unsigned accepted[$];
    byte unsigned tx_seen[$];
    byte unsigned rx_q[$];
    bit           ovf_model = 1'b0;

    bit hold_busy       = 1'b0;
    int busy_left       = 0;
    int busy_violations = 0;
    int frame_lo        = 3;
    int frame_hi        = 12;
    int rd_pulses       = 0;

    uart_bridge #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset_i(reset_i), .cpu_wr_i(cpu_wr_i), .cpu_rd_i(cpu_rd_i),
        .cpu_reg_i(cpu_reg_i), .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o),
        .uart_tx_data_o(uart_tx_data_o), .uart_wr_o(uart_wr_o), .uart_busy_i(uart_busy_i),
        .uart_rx_data_i(uart_rx_data_i), .uart_valid_i(uart_valid_i), .uart_rd_o(uart_rd_o),
        .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    // uart transmitter: busy rises in the launch cycle and stays up for one frame
    initial begin
        uart_busy_i = 1'b0;
        forever begin
            @(negedge clk);
            if (reset_i) begin
                busy_left = 0;
            end else if (uart_wr_o) begin
                if (uart_busy_i) busy_violations++;
                tx_seen.push_back(uart_tx_data_o);
                busy_left = int'($urandom_range(frame_hi, frame_lo));
            end else if (busy_left > 0) begin
                busy_left--;
            end
            uart_busy_i = hold_busy || (busy_left > 0);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (uart_rd_o) rd_pulses++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_status(input int txc, input int rxc, input bit ovf);
        logic [31:0] s;
        s      = '0;
        s[0]   = (txc == DEPTH);
        s[1]   = (rxc != 0);
        s[2]   = (txc == 0);
        s[3]   = (rxc == DEPTH);
        s[4]   = ovf;
        s[15:8]  = rxc[7:0];
        s[23:16] = txc[7:0];
        return s;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic r, input byte unsigned d);
        @(posedge clk); #1;
        cpu_reg_i  = r;
        cpu_data_i = d;
        cpu_wr_i   = 1'b1;
        @(posedge clk); #1;
        cpu_wr_i   = 1'b0;
    endtask

    task automatic cpu_read(input logic r, output logic [31:0] d);
        @(posedge clk); #1;
        cpu_reg_i = r;
        cpu_rd_i  = 1'b1;
        #1;
        d = cpu_data_o;
        @(posedge clk); #1;
        cpu_rd_i  = 1'b0;
    endtask

    task automatic peek_status(output logic [31:0] d);
        cpu_reg_i = REG_STATUS;
        #1;
        d = cpu_data_o;
    endtask

    task automatic push_tx(input byte unsigned b);
        cpu_write(REG_DATA, b);
        if (accepted.size() - tx_seen.size() >= DEPTH) ovf_model = 1'b1;
        else accepted.push_back(b);
    endtask

    task automatic rx_send(input byte unsigned b);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        uart_rx_data_i = b;
        uart_valid_i   = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (uart_rd_o) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        uart_valid_i = 1'b0;
        chk("rx_ack", 32'(ok), 32'd1);
        rx_q.push_back(b);
    endtask

    task automatic drain_and_compare(input string tag);
        int k;
        k = 0;
        while ((tx_seen.size() != accepted.size() || uart_busy_i) && k < 3000) begin
            tick(1);
            k++;
        end
        chk({tag, "_timeout"}, 32'(k < 3000), 32'd1);
        tick(3);
        chk({tag, "_count"}, tx_seen.size(), accepted.size());
        for (int i = 0; i < accepted.size() && i < tx_seen.size(); i++)
            chk({tag, "_byte"}, tx_seen[i], accepted[i]);
        accepted.delete();
        tx_seen.delete();
    endtask

    initial begin
        logic [31:0]  d;
        byte unsigned b, b17;
        byte unsigned fixed[3];
        int           base;
        bit           ok;

        cpu_wr_i = 1'b0; cpu_rd_i = 1'b0; cpu_reg_i = 1'b0; cpu_data_i = '0;
        uart_rx_data_i = '0; uart_valid_i = 1'b0; reset_i = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset_i = 1'b0;

        // Reset state
        chk("rst_wr", uart_wr_o, 32'd0);
        chk("rst_rd", uart_rd_o, 32'd0);
        chk("rst_txdata", uart_tx_data_o, 32'd0);
        chk("rst_irq", irq_o, 32'd0);
        peek_status(d);
        chk("rst_status", d, exp_status(0, 0, 0));

        // Three fixed bytes, in order, each launched only after busy falls
        fixed[0] = 8'h41; fixed[1] = 8'h42; fixed[2] = 8'h43;
        for (int i = 0; i < 3; i++) begin
            push_tx(fixed[i]);
            tick(2);
        end
        drain_and_compare("tx_fixed");
        peek_status(d);
        chk("tx_fixed_status", d, exp_status(0, 0, 0));

        // Random bytes with random gaps while the uart drains
        for (int i = 0; i < 12; i++) begin
            b = 8'($urandom);
            push_tx(b);
            tick(int'($urandom_range(3, 0)));
        end
        drain_and_compare("tx_rand");
        chk("tx_busy_violations", busy_violations, 32'd0);

        // Overflow with busy held: 16 kept, 17th dropped, status read clears flag
        hold_busy = 1'b1;
        tick(2);
        for (int i = 0; i < DEPTH + 1; i++) push_tx(8'($urandom));
        cpu_read(REG_STATUS, d);
        chk("ovf_status1", d, exp_status(DEPTH, 0, ovf_model));
        ovf_model = 1'b0;
        cpu_read(REG_STATUS, d);
        chk("ovf_status2", d, exp_status(DEPTH, 0, 0));
        chk("ovf_no_launch", tx_seen.size(), 32'd0);
        hold_busy = 1'b0;
        drain_and_compare("tx_ovf");

        // Single received byte
        base = rd_pulses;
        rx_send(8'h5A);
        tick(2);
        chk("rx_one_pulse", rd_pulses - base, 32'd1);
        chk("rx_irq_set", irq_o, 32'd1);
        peek_status(d);
        chk("rx_one_status", d, exp_status(0, rx_q.size(), 0));
        cpu_read(REG_DATA, d);
        chk("rx_one_data", d, {24'd0, rx_q.pop_front()});
        tick(2);
        chk("rx_irq_clear", irq_o, 32'd0);
        peek_status(d);
        chk("rx_empty_status", d, exp_status(0, rx_q.size(), 0));

        // Fill RX, 17th byte backpressured until one CPU read frees a slot
        for (int i = 0; i < DEPTH; i++) rx_send(8'($urandom));
        b17 = 8'($urandom);
        @(posedge clk); #1;
        uart_rx_data_i = b17;
        uart_valid_i   = 1'b1;
        base = rd_pulses;
        tick(10);
        chk("rx_backpressure", rd_pulses - base, 32'd0);
        peek_status(d);
        chk("rx_full_status", d, exp_status(0, DEPTH, 0));
        cpu_read(REG_DATA, d);
        chk("rx_full_data", d, {24'd0, rx_q.pop_front()});
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (uart_rd_o) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        uart_valid_i = 1'b0;
        chk("rx_17_accepted", 32'(ok), 32'd1);
        rx_q.push_back(b17);
        tick(2);
        peek_status(d);
        chk("rx_refill_status", d, exp_status(0, rx_q.size(), 0));
        while (rx_q.size() > 0) begin
            cpu_read(REG_DATA, d);
            chk("rx_drain_data", d, {24'd0, rx_q.pop_front()});
        end
        peek_status(d);
        chk("rx_drained_status", d, exp_status(0, 0, 0));

        // Held read strobe pops exactly once
        for (int i = 0; i < 3; i++) rx_send(8'($urandom));
        @(posedge clk); #1;
        cpu_reg_i = REG_DATA;
        cpu_rd_i  = 1'b1;
        #1;
        chk("held_rd_data", cpu_data_o, {24'd0, rx_q[0]});
        repeat (5) @(posedge clk);
        #1 cpu_rd_i = 1'b0;
        void'(rx_q.pop_front());
        peek_status(d);
        chk("held_rd_status", d, exp_status(0, rx_q.size(), 0));
        while (rx_q.size() > 0) begin
            cpu_read(REG_DATA, d);
            chk("held_rd_rest", d, {24'd0, rx_q.pop_front()});
        end

        // Reset during a long frame with 4 bytes queued
        frame_lo = 60;
        frame_hi = 60;
        for (int i = 0; i < 5; i++) push_tx(8'($urandom));
        peek_status(d);
        chk("pre_reset_launched", tx_seen.size(), 32'd1);
        chk("pre_reset_status", d, exp_status(accepted.size() - tx_seen.size(), 0, 0));
        @(posedge clk); #1 reset_i = 1'b1;
        @(posedge clk); #1 reset_i = 1'b0;
        accepted.delete();
        peek_status(d);
        chk("post_reset_status", d, exp_status(0, 0, 0));
        chk("post_reset_wr", uart_wr_o, 32'd0);
        chk("post_reset_txdata", uart_tx_data_o, 32'd0);
        chk("post_reset_irq", irq_o, 32'd0);
        tick(6);
        chk("post_reset_no_launch", tx_seen.size(), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
